// File: rtl/mod_ctrl.sv
// mod_ctrl: sequencing controller for unsigned modulo by repeated subtraction.
//
// An accepted start latches the dividend into the remainder register and the
// divisor into an internal register. The datapath then takes one
// subtract-and-compare step per clock until remainder < divisor. Remainder and
// quotient are presented with a one-cycle done pulse. A zero divisor
// short-circuits to DONE with err set.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   start      request pulse, sampled only in IDLE
//   abort      cancels an operation in RUN (no done pulse, results cleared)
//   a, b       dividend / divisor, sampled on the accepting edge
//   busy       high while iterating (RUN)
//   done       one-cycle pulse, results valid in this cycle
//   err        divide-by-zero flag, held until the next accepted start
//   remainder  a mod b, held until the next accepted start
//   quotient   floor(a / b), held until the next accepted start
module mod_ctrl #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [WIDTH-1:0] remainder,
   output logic [WIDTH-1:0] quotient
);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StRun  = 2'd1;
   localparam logic [1:0] StDone = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] div_q, div_d;
   logic             err_q, err_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   // Extra bit gives the borrow; bit WIDTH-1 of the difference alone would
   // misjudge operands at or above 2^(WIDTH-1).
   logic [WIDTH:0]   diff;
   logic             rem_lt_div;

   assign diff       = {1'b0, rem_q} - {1'b0, div_q};
   assign rem_lt_div = diff[WIDTH];

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      quot_d  = quot_q;
      div_d   = div_q;
      err_d   = err_q;

      case (state_q)
         StIdle: begin
            if (start) begin
               rem_d  = a;
               div_d  = b;
               quot_d = '0;
               err_d  = 1'b0;
               if (b == '0) begin
                  err_d   = 1'b1;
                  state_d = StDone;
               end else begin
                  state_d = StRun;
               end
            end
         end

         StRun: begin
            if (abort) begin
               rem_d   = '0;
               quot_d  = '0;
               state_d = StIdle;
            end else if (rem_lt_div) begin
               state_d = StDone;
            end else begin
               // Taken only when remainder >= divisor, so no underflow.
               rem_d  = diff[WIDTH-1:0];
               quot_d = quot_q + WIDTH'(1);
            end
         end

         StDone: begin
            state_d = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase

      // Status flags are registered from the next state so they line up with
      // the state they describe and never depend combinationally on inputs.
      busy_d = (state_d == StRun);
      done_d = (state_d == StDone);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         rem_q   <= '0;
         quot_q  <= '0;
         div_q   <= '0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         quot_q  <= quot_d;
         div_q   <= div_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign remainder = rem_q;
   assign quotient  = quot_q;

endmodule

// File: tb/tb_mod_ctrl.sv
// Self-checking bench for mod_ctrl. Expected values come from plain a/b and
// a%b arithmetic plus the cycle-level timing rules of the controller.
module tb_mod_ctrl;

   localparam int unsigned WIDTH = 32;

   logic             clk;
   logic             rst;
   logic             start;
   logic             abort;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic             err;
   logic [WIDTH-1:0] remainder;
   logic [WIDTH-1:0] quotient;

   int n_checks;
   int n_errors;

   mod_ctrl #(
      .WIDTH (WIDTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .abort     (abort),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .remainder (remainder),
      .quotient  (quotient)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_outs(input string tag, input logic eb, input logic ed, input logic ee,
                             input logic [WIDTH-1:0] er, input logic [WIDTH-1:0] eq);
      check_eq({tag, ".busy"}, 64'(busy), 64'(eb));
      check_eq({tag, ".done"}, 64'(done), 64'(ed));
      check_eq({tag, ".err"}, 64'(err), 64'(ee));
      check_eq({tag, ".rem"}, 64'(remainder), 64'(er));
      check_eq({tag, ".quot"}, 64'(quotient), 64'(eq));
   endtask

   // One operation, checked every cycle. Cycle 0 is the cycle start is
   // sampled; inputs for cycle k are driven at the negedge where cycle k's
   // outputs are checked. abort_cyc / rst_cyc / ign_cyc = 0 means unused.
   task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                         input int abort_cyc, input int rst_cyc, input int ign_cyc);
      logic [WIDTH-1:0] q;
      logic [WIDTH-1:0] r;
      logic             ez;
      int               end_c;
      int               term_c;
      bit               killed;

      ez = (tb_v == '0);
      if (ez) begin
         q     = '0;
         r     = ta;
         end_c = 1;
      end else begin
         q     = ta / tb_v;
         r     = ta % tb_v;
         end_c = int'(q) + 2;
      end
      term_c = end_c;
      killed = 1'b0;
      if (rst_cyc > 0 && rst_cyc < end_c) begin
         term_c = rst_cyc + 1;
         killed = 1'b1;
      end
      if (!ez && abort_cyc > 0 && abort_cyc <= int'(q) + 1 && abort_cyc + 1 < term_c + 1) begin
         if (!killed || abort_cyc + 1 < term_c) begin
            term_c = abort_cyc + 1;
            killed = 1'b1;
         end
      end

      @(negedge clk);
      a     = ta;
      b     = tb_v;
      start = 1'b1;
      abort = 1'b0;
      rst   = 1'b0;

      for (int k = 1; k <= term_c; k++) begin
         @(posedge clk);
         @(negedge clk);
         start = 1'b0;
         abort = 1'b0;
         rst   = 1'b0;
         a     = $urandom;
         b     = $urandom;
         if (killed && k == term_c) begin
            check_outs("kill", 1'b0, 1'b0, 1'b0, '0, '0);
         end else if (k == end_c) begin
            check_outs("done", 1'b0, 1'b1, ez, r, q);
         end else begin
            check_outs("run", 1'b1, 1'b0, 1'b0, ta - WIDTH'(k - 1) * tb_v, WIDTH'(k - 1));
         end
         if (k == abort_cyc) abort = 1'b1;
         if (k == rst_cyc) rst = 1'b1;
         if (k == ign_cyc) begin
            start = 1'b1;
            a     = 32'd8;
            b     = 32'd8;
         end
      end

      // abort in IDLE must be ignored; results stay held.
      abort = 1'b1;
      @(posedge clk);
      @(negedge clk);
      abort = 1'b0;
      if (killed) check_outs("held", 1'b0, 1'b0, 1'b0, '0, '0);
      else        check_outs("held", 1'b0, 1'b0, ez, r, q);
   endtask

   initial begin
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;

      n_checks = 0;
      n_errors = 0;
      rst      = 1'b1;
      start    = 1'b0;
      abort    = 1'b0;
      a        = '0;
      b        = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_outs("reset", 1'b0, 1'b0, 1'b0, '0, '0);
      rst = 1'b0;

      run_op(32'd17, 32'd5, 0, 0, 0);
      run_op(32'd3, 32'd7, 0, 0, 0);
      run_op(32'd20, 32'd5, 0, 0, 0);
      run_op(32'd42, 32'd0, 0, 0, 0);
      run_op(32'd9, 32'd4, 0, 0, 0);
      run_op(32'hFFFF_FFFF, 32'h8000_0000, 0, 0, 0);
      run_op(32'd100, 32'd3, 0, 0, 2);
      run_op(32'd100, 32'd3, 4, 0, 0);
      run_op(32'd50, 32'd2, 0, 6, 0);
      run_op(32'd7, 32'd2, 0, 0, 0);
      run_op(32'd0, 32'd1, 0, 0, 0);

      for (int i = 0; i < 30; i++) begin
         case (i % 3)
            0: begin
               ra = WIDTH'($urandom_range(0, 300));
               rb = WIDTH'($urandom_range(0, 20));
            end
            1: begin
               ra = $urandom;
               rb = ($urandom | 32'h8000_0000) >> $urandom_range(0, 4);
            end
            default: begin
               ra = $urandom | 32'h8000_0000;
               rb = ra >> $urandom_range(0, 5);
            end
         endcase
         if ($urandom_range(0, 3) == 0) begin
            run_op(ra, rb, int'($urandom_range(1, 6)), 0, 0);
         end else begin
            run_op(ra, rb, 0, 0, 0);
         end
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mod_ctrl.md
# mod_ctrl

Sequencing controller for the processor's unsigned modulo/remainder operation. It implements modulo by repeated subtraction: it loads the operands, iterates a subtract-and-compare datapath one step per clock until the remainder is below the divisor, and then returns remainder and quotient through a start/busy/done handshake. It sits beside the ALU and is started by the main control FSM whenever a modulo-class instruction issues.

## Interface
- WIDTH, 32, operand/result width in bits

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request pulse; sampled only in IDLE
- abort  in  1  cancels an operation in RUN
- a  in  WIDTH  dividend, unsigned; sampled on the accepting edge
- b  in  WIDTH  divisor, unsigned; sampled on the accepting edge
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse; results are valid in this cycle
- err  out  1  divide-by-zero flag; valid with done and held until the next accepted start
- remainder  out  WIDTH  a mod b; held until the next accepted start
- quotient  out  WIDTH  floor(a/b), i.e. the subtraction count; held until the next accepted start

## Operation
- States: IDLE, RUN, DONE. Reset forces IDLE and clears busy, done, err, remainder and quotient to 0.
- IDLE, start=1:
  - Latch a into the remainder register and b into an internal divisor register.
  - Clear quotient and err.
  - If b==0: set err=1, keep remainder=a and quotient=0, and go to DONE.
  - Otherwise go to RUN.
- IDLE, start=0: hold all outputs.
- RUN, each cycle, highest priority first:
  - abort=1: go to IDLE, clear remainder and quotient to 0, no done pulse.
  - remainder < divisor (unsigned): go to DONE.
  - Otherwise: remainder <= remainder - divisor, quotient <= quotient + 1, stay in RUN.
- DONE: assert done for exactly this cycle, then go to IDLE unconditionally.
- Comparison is fully unsigned. It uses the borrow of a WIDTH+1-bit subtraction, not bit WIDTH-1 of the difference, so operands at or above 2^(WIDTH-1) compare correctly.
- Subtraction never underflows: it is taken only when remainder >= divisor. quotient cannot overflow, since quotient <= a.
- start is ignored in RUN and DONE; no queuing, and operand changes while busy have no effect.
- abort is ignored outside RUN.
- rst has priority over every input in every state. Reset mid-RUN returns to IDLE with all outputs 0 and no done pulse.

## Timing
- Cycle 0 is the cycle in which start is sampled high in IDLE.
- b==0: done=1, err=1 in cycle 1.
- b!=0 with q=floor(a/b):
  - busy=1 in cycles 1..q+1.
  - done=1 in cycle q+2.
  - Total latency is q+2 cycles.
- a<b: done in cycle 2, quotient=0, remainder=a.
- The earliest next start is accepted in cycle q+3, the first IDLE cycle after DONE.
- Worst-case latency is unbounded by design (a=2^WIDTH-1, b=1 gives 2^WIDTH+1 cycles). The issuing controller uses abort for timeouts.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- a=17, b=5, start pulse: busy high in cycles 1-4; done in cycle 5; remainder=2, quotient=3, err=0.
- a=3, b=7: done in cycle 2; remainder=3, quotient=0. a=20, b=5: done in cycle 6; remainder=0, quotient=4.
- a=42, b=0: done and err in cycle 1; remainder=42, quotient=0. The next start with a=9, b=4 clears err and yields remainder=1, quotient=2.
- a=0xFFFFFFFF, b=0x80000000: done in cycle 3; remainder=0x7FFFFFFF, quotient=1. This checks the unsigned compare.
- a=100, b=3: in cycle 2 drive start with a=8, b=8; it is ignored, and the result is remainder=1, quotient=33 in cycle 35. Separately, a=100, b=3 with abort in cycle 4: busy=0 in cycle 5, no done, remainder=quotient=0.
- a=50, b=2 with rst high in cycle 6: all outputs 0 in cycle 7 and state IDLE; a fresh start (a=7, b=2) then completes normally with remainder=1, quotient=3.
